// File: rtl/framebuffer_arbiter_if.sv
// Bundle between the framebuffer arbiter, the display/loader clients and the BRAM port.
// The slave modport is the arbiter's view; master is the client/BRAM side.
interface framebuffer_arbiter_if #(
  parameter int HALF_ADDR_WIDTH = 14,
  parameter int DATA_WIDTH      = 64
);
  logic                       rd_req;
  logic [HALF_ADDR_WIDTH-1:0] rd_addr;
  logic                       rd_gnt;
  logic                       rd_valid;
  logic [DATA_WIDTH-1:0]      rd_data;
  logic                       wr_req;
  logic [HALF_ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]      wr_data;
  logic                       wr_gnt;
  logic                       wr_ready;
  logic                       wr_frame_done;
  logic                       frame_end;
  logic [HALF_ADDR_WIDTH:0]   bram_addr;
  logic [DATA_WIDTH-1:0]      bram_din;
  logic                       bram_we;
  logic [DATA_WIDTH-1:0]      bram_dout;
  logic                       front_sel;
  logic                       swap_pending;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_frame_done, frame_end, bram_dout,
    output rd_gnt, rd_valid, rd_data, wr_gnt, wr_ready, bram_addr, bram_din, bram_we,
           front_sel, swap_pending
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_frame_done, frame_end, bram_dout,
    input  rd_gnt, rd_valid, rd_data, wr_gnt, wr_ready, bram_addr, bram_din, bram_we,
           front_sel, swap_pending
  );
endinterface

// File: rtl/framebuffer_arbiter.sv
// Double-buffered framebuffer arbiter: display reads the front half, loader writes the back
// half, one BRAM access per cycle, halves swap at a display frame end after a completed load.
module framebuffer_arbiter #(
  parameter int HALF_ADDR_WIDTH = 14,
  parameter int DATA_WIDTH      = 64,
  parameter int RD_LATENCY      = 2,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  framebuffer_arbiter_if.slave  fb
);
  localparam int SW     = $clog2(STARVE_LIMIT + 1);
  localparam int STAGES = RD_LATENCY - 1;

  typedef enum logic {S_IDLE, S_PENDING} swap_state_t;

  swap_state_t     state, state_nx;
  logic            front_q, front_nx;
  logic [SW-1:0]   starve_cnt;
  logic [STAGES:0] vld_pipe;
  logic            wr_elig, starved, wr_win;

  // Reads win unless the eligible write has waited STARVE_LIMIT cycles.
  always_comb begin
    wr_elig      = fb.wr_req & (state == S_IDLE);
    starved      = (starve_cnt == SW'(STARVE_LIMIT));
    wr_win       = wr_elig & (~fb.rd_req | starved);
    fb.wr_gnt    = wr_win;
    fb.rd_gnt    = fb.rd_req & ~wr_win;
    fb.bram_we   = wr_win;
    fb.bram_addr = wr_win ? {~front_q, fb.wr_addr} : {front_q, fb.rd_addr};
    fb.bram_din  = fb.wr_data;
  end

  always_ff @(posedge clock_in) begin
    if (reset_in)                 starve_cnt <= '0;
    else if (!wr_elig || wr_win)  starve_cnt <= '0;
    else if (!starved)            starve_cnt <= starve_cnt + 1'b1;
  end

  // Grant travels alongside the BRAM's own read pipeline; reset drops in-flight reads.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= fb.rd_gnt;
      for (int i = 1; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign fb.rd_valid = vld_pipe[STAGES];
  assign fb.rd_data  = vld_pipe[STAGES] ? fb.bram_dout : '0;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state   <= S_IDLE;
      front_q <= 1'b0;
    end else begin
      state   <= state_nx;
      front_q <= front_nx;
    end
  end

  // frame_end in IDLE is dropped; wr_frame_done in PENDING is dropped.
  always_comb begin
    state_nx = state;
    front_nx = front_q;
    case (state)
      S_IDLE:    if (fb.wr_frame_done) state_nx = S_PENDING;
      S_PENDING: if (fb.frame_end) begin
                   state_nx = S_IDLE;
                   front_nx = ~front_q;
                 end
      default:   state_nx = S_IDLE;
    endcase
  end

  assign fb.front_sel    = front_q;
  assign fb.swap_pending = (state == S_PENDING);
  assign fb.wr_ready     = (state == S_IDLE);
endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Bench for framebuffer_arbiter: BRAM model with 2-cycle read, read-data scoreboard, scenario tasks.
module tb_framebuffer_arbiter;
  localparam int HAW = 14;
  localparam int DW  = 64;
  localparam int RL  = 2;
  localparam int SL  = 8;
  localparam int NW  = 1 << (HAW + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  framebuffer_arbiter_if #(.HALF_ADDR_WIDTH(HAW), .DATA_WIDTH(DW)) fb ();

  framebuffer_arbiter #(
    .HALF_ADDR_WIDTH(HAW), .DATA_WIDTH(DW), .RD_LATENCY(RL), .STARVE_LIMIT(SL)
  ) dut (
    .clock_in (clk),
    .reset_in (rst),
    .fb       (fb)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  function automatic logic [DW-1:0] pat(int i);
    return {16'hCAFE, 16'(i), 32'(i * 7 + 1)};
  endfunction

  // BRAM model: write-on-grant, read data two edges after the address.
  logic [DW-1:0] mem [0:NW-1];
  logic [DW-1:0] dpipe1;
  logic          init_done = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!init_done) begin
      for (int i = 0; i < NW; i++) mem[i] <= pat(i);
      init_done <= 1'b1;
    end else if (fb.bram_we) begin
      mem[fb.bram_addr] <= fb.bram_din;
    end
    dpipe1       <= mem[fb.bram_addr];
    fb.bram_dout <= dpipe1;
  end

  // Expected memory contents and expected displayed half, kept by the bench alone.
  logic [DW-1:0] shadow [0:NW-1];
  logic          exp_front = 1'b0;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } rd_exp_t;
  rd_exp_t sb[$];

  always @(negedge clk) begin
    rd_exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (fb.rd_valid) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL rd_valid_unexpected got_data=%h at cyc=%0d", fb.rd_data, cyc);
        end else begin
          e = sb.pop_front();
          if (fb.rd_data !== e.data || cyc !== e.cyc + RL) begin
            failures++;
            $display("FAIL rd_data got=%h want=%h cyc=%0d want_cyc=%0d",
                     fb.rd_data, e.data, cyc, e.cyc + RL);
          end
        end
      end
      if (fb.rd_gnt) begin
        e.data = shadow[{exp_front, fb.rd_addr}];
        e.cyc  = cyc;
        sb.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [DW-1:0] g [8];
    logic [DW-1:0] w [8];
    string         n [8];
    rst = 1'b1;
    repeat (3) tick();
    #1;
    g[0] = 64'(fb.front_sel);    w[0] = 0; n[0] = "rst_front_sel";
    g[1] = 64'(fb.swap_pending); w[1] = 0; n[1] = "rst_swap_pending";
    g[2] = 64'(fb.rd_gnt);       w[2] = 0; n[2] = "rst_rd_gnt";
    g[3] = 64'(fb.rd_valid);     w[3] = 0; n[3] = "rst_rd_valid";
    g[4] = 64'(fb.wr_gnt);       w[4] = 0; n[4] = "rst_wr_gnt";
    g[5] = 64'(fb.bram_we);      w[5] = 0; n[5] = "rst_bram_we";
    g[6] = fb.rd_data;           w[6] = 0; n[6] = "rst_rd_data";
    g[7] = 64'(fb.wr_ready);     w[7] = 1; n[7] = "rst_wr_ready";
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (g[i] !== w[i]) begin
        failures++;
        $display("FAIL %s got=%h want=%h", n[i], g[i], w[i]);
      end
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_basic();
    fb.rd_req  = 1'b1;
    fb.rd_addr = 14'd5;
    #1;
    checks++;
    if (fb.rd_gnt !== 1'b1 || fb.bram_addr !== 15'h0005 || fb.bram_we !== 1'b0) begin
      failures++;
      $display("FAIL read_grant gnt=%b addr=%h we=%b want gnt=1 addr=0005 we=0",
               fb.rd_gnt, fb.bram_addr, fb.bram_we);
    end
    tick();
    fb.rd_req = 1'b0;
    for (int i = 0; i < 8 && sb.size() != 0; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL read_drain pending=%0d want=0", sb.size());
    end
  endtask

  task automatic test_write_swap();
    logic [DW-1:0] d;
    d = 64'hDEAD_BEEF_0000_0001;
    fb.wr_req  = 1'b1;
    fb.wr_addr = 14'd3;
    fb.wr_data = d;
    #1;
    checks++;
    if (fb.wr_gnt !== 1'b1 || fb.rd_gnt !== 1'b0 || fb.bram_addr !== 15'h4003 ||
        fb.bram_we !== 1'b1 || fb.bram_din !== d) begin
      failures++;
      $display("FAIL write_grant gnt=%b rgnt=%b addr=%h we=%b din=%h want 1 0 4003 1 %h",
               fb.wr_gnt, fb.rd_gnt, fb.bram_addr, fb.bram_we, fb.bram_din, d);
    end
    shadow[{~exp_front, 14'd3}] = d;
    tick();
    fb.wr_req        = 1'b0;
    fb.wr_frame_done = 1'b1;
    tick();
    fb.wr_frame_done = 1'b0;
    #1;
    checks++;
    if (fb.swap_pending !== 1'b1 || fb.wr_ready !== 1'b0 || fb.front_sel !== 1'b0) begin
      failures++;
      $display("FAIL pending_state pend=%b ready=%b front=%b want 1 0 0",
               fb.swap_pending, fb.wr_ready, fb.front_sel);
    end
    fb.frame_end = 1'b1;
    tick();
    fb.frame_end = 1'b0;
    exp_front    = 1'b1;
    #1;
    checks++;
    if (fb.front_sel !== 1'b1 || fb.swap_pending !== 1'b0) begin
      failures++;
      $display("FAIL swap front=%b pend=%b want 1 0", fb.front_sel, fb.swap_pending);
    end
    fb.rd_req  = 1'b1;
    fb.rd_addr = 14'd3;
    #1;
    checks++;
    if (fb.rd_gnt !== 1'b1 || fb.bram_addr !== 15'h4003) begin
      failures++;
      $display("FAIL read_after_swap gnt=%b addr=%h want 1 4003", fb.rd_gnt, fb.bram_addr);
    end
    tick();
    fb.rd_req = 1'b0;
    for (int i = 0; i < 8 && sb.size() != 0; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL swap_drain pending=%0d want=0", sb.size());
    end
  endtask

  task automatic test_starve();
    logic gw, gr, ew;
    fb.rd_req  = 1'b1;
    fb.rd_addr = 14'd0;
    fb.wr_req  = 1'b1;
    fb.wr_addr = 14'd20;
    fb.wr_data = 64'h5151_0000_0000_0014;
    for (int k = 1; k <= 18; k++) begin
      #1;
      ew = (k == 9) || (k == 18);
      gw = fb.wr_gnt;
      gr = fb.rd_gnt;
      checks++;
      if (gw !== ew || gr !== !ew) begin
        failures++;
        $display("FAIL starve_k%0d wr_gnt=%b rd_gnt=%b want %b %b", k, gw, gr, ew, !ew);
      end
      if (gw === 1'b1) shadow[{~exp_front, fb.wr_addr}] = fb.wr_data;
      tick();
      if (gw === 1'b1) begin
        fb.wr_addr = fb.wr_addr + 1'b1;
        fb.wr_data = fb.wr_data + 64'd1;
      end
      if (gr === 1'b1) fb.rd_addr = fb.rd_addr + 1'b1;
    end
    fb.rd_req = 1'b0;
    fb.wr_req = 1'b0;
    for (int i = 0; i < 8 && sb.size() != 0; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL starve_drain pending=%0d want=0", sb.size());
    end
  endtask

  task automatic test_pending_blocks_write();
    logic [DW-1:0] d;
    d = 64'h1234_5678_9ABC_DEF0;
    fb.wr_frame_done = 1'b1;
    tick();
    fb.wr_frame_done = 1'b0;
    fb.wr_req        = 1'b1;
    fb.wr_addr       = 14'd7;
    fb.wr_data       = d;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (fb.wr_ready !== 1'b0 || fb.wr_gnt !== 1'b0 || fb.swap_pending !== 1'b1) begin
        failures++;
        $display("FAIL pending_hold_%0d ready=%b gnt=%b pend=%b want 0 0 1",
                 k, fb.wr_ready, fb.wr_gnt, fb.swap_pending);
      end
      tick();
    end
    fb.frame_end = 1'b1;
    #1;
    checks++;
    if (fb.wr_gnt !== 1'b0) begin
      failures++;
      $display("FAIL pending_fe_cycle wr_gnt=%b want 0", fb.wr_gnt);
    end
    tick();
    fb.frame_end = 1'b0;
    exp_front    = 1'b0;
    #1;
    checks++;
    if (fb.wr_gnt !== 1'b1 || fb.bram_addr !== 15'h4007 || fb.front_sel !== 1'b0 ||
        fb.wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL pending_release gnt=%b addr=%h front=%b ready=%b want 1 4007 0 1",
               fb.wr_gnt, fb.bram_addr, fb.front_sel, fb.wr_ready);
    end
    shadow[{~exp_front, 14'd7}] = d;
    tick();
    fb.wr_req = 1'b0;
  endtask

  task automatic test_same_cycle();
    fb.wr_frame_done = 1'b1;
    fb.frame_end     = 1'b1;
    tick();
    fb.wr_frame_done = 1'b0;
    fb.frame_end     = 1'b0;
    #1;
    checks++;
    if (fb.swap_pending !== 1'b1 || fb.front_sel !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle pend=%b front=%b want 1 0", fb.swap_pending, fb.front_sel);
    end
    tick();
    tick();
    #1;
    checks++;
    if (fb.front_sel !== 1'b0 || fb.swap_pending !== 1'b1) begin
      failures++;
      $display("FAIL same_cycle_hold front=%b pend=%b want 0 1", fb.front_sel, fb.swap_pending);
    end
    fb.frame_end = 1'b1;
    tick();
    fb.frame_end = 1'b0;
    exp_front    = 1'b1;
    #1;
    checks++;
    if (fb.front_sel !== 1'b1 || fb.swap_pending !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_swap front=%b pend=%b want 1 0", fb.front_sel, fb.swap_pending);
    end
    // Reads the word the pending-window write placed in this half.
    fb.rd_req  = 1'b1;
    fb.rd_addr = 14'd7;
    tick();
    fb.rd_req = 1'b0;
    for (int i = 0; i < 8 && sb.size() != 0; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL same_cycle_drain pending=%0d want=0", sb.size());
    end
  endtask

  task automatic test_back_to_back_reset();
    fb.rd_req  = 1'b1;
    fb.rd_addr = 14'd9;
    #1;
    checks++;
    if (fb.rd_gnt !== 1'b1) begin
      failures++;
      $display("FAIL b2b_gnt0 got=%b want=1", fb.rd_gnt);
    end
    tick();
    fb.rd_addr = 14'd10;
    rst        = 1'b1;
    #1;
    checks++;
    if (fb.rd_gnt !== 1'b1) begin
      failures++;
      $display("FAIL b2b_gnt1 got=%b want=1", fb.rd_gnt);
    end
    tick();
    fb.rd_req = 1'b0;
    rst       = 1'b0;
    exp_front = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (fb.rd_valid !== 1'b0) begin
        failures++;
        $display("FAIL b2b_dropped_%0d rd_valid=%b want=0", k, fb.rd_valid);
      end
      tick();
    end
    checks++;
    if (fb.front_sel !== 1'b0 || fb.swap_pending !== 1'b0) begin
      failures++;
      $display("FAIL b2b_reset_state front=%b pend=%b want 0 0", fb.front_sel, fb.swap_pending);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NW; i++) shadow[i] = pat(i);
    fb.rd_req        = 1'b0;
    fb.rd_addr       = '0;
    fb.wr_req        = 1'b0;
    fb.wr_addr       = '0;
    fb.wr_data       = '0;
    fb.wr_frame_done = 1'b0;
    fb.frame_end     = 1'b0;
    test_reset();
    test_read_basic();
    test_write_swap();
    test_starve();
    test_pending_blocks_write();
    test_same_cycle();
    test_back_to_back_reset();
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/framebuffer_arbiter.md
# framebuffer_arbiter

Shares the single-port 64-bit framebuffer BRAM between the display readout path and the network frame loader. The BRAM is split into two halves (front/back) and the block double-buffers them. The display always reads the front half and the loader always writes the back half. The halves swap only at a display frame boundary, after the loader has declared a complete frame. The block sits between the display controller, the packet-to-framebuffer loader, and the `blk_mem_gen` framebuffer instance.

## Interface
Parameters:
- `HALF_ADDR_WIDTH`, default 14: address bits within one half; BRAM address width is `HALF_ADDR_WIDTH+1`.
- `DATA_WIDTH`, default 64: framebuffer word width.
- `RD_LATENCY`, default 2: BRAM read latency in cycles; must be ≥1.
- `STARVE_LIMIT`, default 8: cycles a ready write may wait before it pre-empts reads; must be ≥1.

Ports:
- `clock_in` in 1: sole clock.
- `reset_in` in 1: synchronous, active-high reset.
- `rd_req` in 1: display read request; held with `rd_addr` until `rd_gnt`.
- `rd_addr` in HALF_ADDR_WIDTH: word index within the front half.
- `rd_gnt` out 1: one-cycle pulse; read accepted this cycle.
- `rd_valid` out 1: one-cycle pulse; `rd_data` is valid.
- `rd_data` out DATA_WIDTH: read data, equal to `bram_dout` when `rd_valid` is high.
- `wr_req` in 1: loader write request; held with `wr_addr`/`wr_data` until `wr_gnt`.
- `wr_addr` in HALF_ADDR_WIDTH: word index within the back half.
- `wr_data` in DATA_WIDTH: write word.
- `wr_gnt` out 1: one-cycle pulse; write performed this cycle.
- `wr_ready` out 1: high when the back half may be written (`~swap_pending`).
- `wr_frame_done` in 1: pulse; the back half holds a complete frame.
- `frame_end` in 1: pulse from the display at the end of a frame.
- `bram_addr` out HALF_ADDR_WIDTH+1: `{half_sel, index}`.
- `bram_din` out DATA_WIDTH: write data to the BRAM.
- `bram_we` out 1: BRAM write enable.
- `bram_dout` in DATA_WIDTH: BRAM read data.
- `front_sel` out 1: half currently displayed.
- `swap_pending` out 1: a completed back frame is waiting for swap.

## Operation
- At most one BRAM access per cycle.
- A read grant drives `bram_addr={front_sel,rd_addr}` and `bram_we=0`.
- A write grant drives `bram_addr={~front_sel,wr_addr}`, `bram_din=wr_data` and `bram_we=1`.
- Address, write enable and data are combinational from the grant decision, valid in the grant cycle.
- Eligible write: `wr_req & wr_ready`.
- Priority: reads win by default.
- `starve_cnt` counts cycles with an eligible write that is not granted, saturating at STARVE_LIMIT.
- When `starve_cnt==STARVE_LIMIT`, an eligible write beats `rd_req` for one grant.
- Any write grant clears `starve_cnt`. A cycle with no eligible write also clears it.
- Read pipeline: a shift register of depth RD_LATENCY carries the grant. `rd_valid` is asserted exactly RD_LATENCY cycles after `rd_gnt`. Back-to-back reads are allowed, one per cycle.
- Swap FSM, two states:
  - IDLE (`swap_pending=0`): `wr_frame_done` moves to PENDING next cycle.
  - PENDING (`swap_pending=1`): `frame_end` toggles `front_sel` and returns to IDLE next cycle. `wr_frame_done` is ignored.
- `frame_end` in IDLE is ignored.
- `wr_frame_done` and `frame_end` high in the same IDLE cycle: go to PENDING; the swap waits for the next `frame_end`.
- The swap takes effect on the cycle after `frame_end`. Reads already granted complete with old-half data. Grants from the next cycle onward use the new `front_sel`.
- `wr_ready=0` in PENDING, so the loader cannot overwrite the frame awaiting display. A held `wr_req` simply waits.

## Timing
- Reset values: `front_sel=0`, `swap_pending=0`, `starve_cnt=0`, read pipeline cleared.
- Outputs at reset: `rd_gnt=rd_valid=wr_gnt=bram_we=0`, `rd_data=0`.
- Reset mid-operation drops in-flight reads. No `rd_valid` is issued for them.
- Grant is combinational from the current request and registered state.
- Read latency from `rd_gnt` to `rd_valid` is RD_LATENCY cycles.
- Write latency is 0: the BRAM is written in the `wr_gnt` cycle.
- Worst-case write wait while eligible: STARVE_LIMIT+1 cycles.
- `front_sel` changes only on the cycle after a `frame_end` in PENDING.

## Test plan
- Reset, then read idx 5 with `front_sel=0` → `rd_gnt` the same cycle, `bram_addr=0x0005`, `rd_valid` 2 cycles later with the preloaded word.
- Write idx 3 = 0xDEAD_BEEF_0000_0001, then `wr_frame_done`, then `frame_end`. Afterwards read idx 3 → data matches, `front_sel=1`. Write grant drove `bram_addr=0x4003`, `bram_we=1`.
- `rd_req` held continuously with `wr_req` eligible → write granted on the 9th cycle (STARVE_LIMIT=8). Reads are granted on all other cycles and the counter resets.
- `wr_frame_done` then `wr_req` → `wr_ready=0`, no `wr_gnt` until the cycle after `frame_end`; then the write goes to half `~front_sel`.
- `wr_frame_done` and `frame_end` in the same IDLE cycle → `swap_pending=1`, `front_sel` unchanged. The next `frame_end` toggles `front_sel`.
- Reset asserted one cycle after 2 back-to-back read grants → no `rd_valid` pulses; `front_sel=0` and `swap_pending=0` afterwards.
